// File: rtl/interrupt_controller.sv
// interrupt_controller: 68030 seven-level IRQ synchroniser, masking, IPL encoder and IACK sequencer
module interrupt_controller #(
    parameter logic [6:0] AUTOVEC_MASK = 7'h7F,
    parameter int         IACK_TIMEOUT = 64,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic [6:0] n_irq,
    input  logic       as,
    input  logic       iack_cycle,
    input  logic [2:0] iack_level,
    input  logic       reg_cs,
    input  logic       reg_sel,
    input  logic       write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [2:0] n_ipl,
    output logic       n_avec,
    output logic [6:0] n_iack,
    output logic       iack_berr
);
    typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;
    localparam logic [7:0] AV8 = {AUTOVEC_MASK, 1'b0};
    localparam logic [7:0] TMO = 8'(IACK_TIMEOUT - 1);
    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][6:0]   sync_q;
    logic [6:0]                    req;
    logic [7:0]                    mask_q, pend8, dec;
    logic [2:0]                    top, ipl_q, lvl_q, lvl_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic                          avec_q, avec_d, berr_q, berr_d;
    logic [6:0]                    iack_q, iack_d;

    assign req       = sync_q[SYNC_STAGES-1];
    assign pend8     = {req[6], req[5:0] & mask_q[6:1], 1'b0};
    assign dec       = 8'b1 << iack_level;
    assign data_out  = reg_cs ? (reg_sel ? {req, 1'b0} : mask_q) : 8'h00;
    assign n_ipl     = ipl_q;
    assign n_avec    = avec_q;
    assign n_iack    = iack_q;
    assign iack_berr = berr_q;

    // IRQ synchroniser chain, active-high after inversion
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= ~n_irq;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // enable mask register; bit 0 has no level and is forced to zero
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) mask_q <= 8'h00;
        else if (reg_cs && write && !reg_sel) mask_q <= data_in & 8'hFE;
    end

    // highest pending level
    always_comb begin
        top = 3'd0;
        for (int i = 1; i < 8; i++) if (pend8[i]) top = 3'(i);
    end

    // registered IPL, frozen while an acknowledge is in progress
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) ipl_q <= 3'b111;
        else if (state_q != ACK) ipl_q <= ~top;
    end

    // IACK sequencer next state and next strobe values
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        avec_d  = avec_q;
        iack_d  = iack_q;
        berr_d  = berr_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (iack_cycle && as) begin
                    lvl_d = iack_level;
                    if (!pend8[iack_level]) begin
                        state_d = DONE;
                        berr_d  = 1'b1;
                    end else begin
                        state_d = ACK;
                        avec_d  = !AV8[iack_level];
                        iack_d  = AV8[iack_level] ? 7'h7F : ~dec[7:1];
                    end
                end
            end
            ACK: begin
                if (!as) begin
                    state_d = IDLE;
                    avec_d  = 1'b1;
                    iack_d  = 7'h7F;
                    berr_d  = 1'b0;
                end else if (!AV8[lvl_q]) begin
                    if (cnt_q == TMO) begin
                        state_d = DONE;
                        iack_d  = 7'h7F;
                        berr_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                if (!as) begin
                    state_d = IDLE;
                    avec_d  = 1'b1;
                    iack_d  = 7'h7F;
                    berr_d  = 1'b0;
                end
            end
        endcase
    end

    // sequencer state and registered strobes
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            lvl_q   <= 3'd0;
            cnt_q   <= 8'd0;
            avec_q  <= 1'b1;
            iack_q  <= 7'h7F;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            avec_q  <= avec_d;
            iack_q  <= iack_d;
            berr_q  <= berr_d;
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scoreboard bench for interrupt_controller
module tb_interrupt_controller;
    logic       clock = 1'b0;
    logic       n_reset;
    logic [6:0] n_irq;
    logic       as, iack_cycle, reg_cs, reg_sel, write;
    logic [2:0] iack_level;
    logic [7:0] data_in, data_out;
    logic [2:0] n_ipl;
    logic       n_avec, iack_berr;
    logic [6:0] n_iack;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    interrupt_controller #(.AUTOVEC_MASK(7'h7B), .IACK_TIMEOUT(64), .SYNC_STAGES(2)) dut (
        .clock(clock), .n_reset(n_reset), .n_irq(n_irq), .as(as), .iack_cycle(iack_cycle),
        .iack_level(iack_level), .reg_cs(reg_cs), .reg_sel(reg_sel), .write(write),
        .data_in(data_in), .data_out(data_out), .n_ipl(n_ipl), .n_avec(n_avec),
        .n_iack(n_iack), .iack_berr(iack_berr)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic chk(input logic [7:0] obs);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic wr_mask(input logic [7:0] d);
        reg_cs = 1'b1; reg_sel = 1'b0; write = 1'b1; data_in = d;
        tick();
        write = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0; n_irq = 7'h7F; as = 1'b0; iack_cycle = 1'b0; iack_level = 3'd0;
        reg_cs = 1'b0; reg_sel = 1'b0; write = 1'b0; data_in = 8'h00;
        tick(2);
        push("rst_ipl", 8'h07);   chk({5'b0, n_ipl});
        push("rst_avec", 8'h01);  chk({7'b0, n_avec});
        push("rst_iack", 8'h7F);  chk({1'b0, n_iack});
        push("rst_berr", 8'h00);  chk({7'b0, iack_berr});
        push("rst_dout", 8'h00);  chk(data_out);
        n_reset = 1'b1;
        tick();
        reg_cs = 1'b1; reg_sel = 1'b0;
        #1 push("mask_rst", 8'h00); chk(data_out);
        wr_mask(8'hFF);
        push("mask_ff", 8'hFE);   chk(data_out);
        reg_sel = 1'b1;
        #1 push("status_idle", 8'h00); chk(data_out);

        wr_mask(8'h00);
        n_irq = 7'h6F;
        tick(4);
        push("masked_l5_ipl", 8'h07); chk({5'b0, n_ipl});
        reg_sel = 1'b1;
        #1 push("status_l5", 8'h20); chk(data_out);
        n_irq = 7'h2F;
        tick(2);
        push("nmi_lat2", 8'h07);  chk({5'b0, n_ipl});
        tick();
        push("nmi_lat3", 8'h00);  chk({5'b0, n_ipl});
        n_irq = 7'h7F;
        tick(4);
        push("idle_ipl", 8'h07);  chk({5'b0, n_ipl});

        wr_mask(8'hFE);
        n_irq = 7'h6D;
        tick(3);
        push("l5_ipl", 8'h02);    chk({5'b0, n_ipl});
        n_irq = 7'h7D;
        tick(2);
        push("l2_lat2", 8'h02);   chk({5'b0, n_ipl});
        tick();
        push("l2_lat3", 8'h05);   chk({5'b0, n_ipl});

        n_irq = 7'h6D;
        tick(3);
        iack_cycle = 1'b1; iack_level = 3'd5; as = 1'b1;
        #1 push("avec_pre", 8'h01); chk({7'b0, n_avec});
        tick();
        push("avec_low", 8'h00);  chk({7'b0, n_avec});
        push("avec_iack", 8'h7F); chk({1'b0, n_iack});
        push("avec_berr", 8'h00); chk({7'b0, iack_berr});
        n_irq = 7'h7F;
        tick(4);
        push("avec_hold", 8'h00); chk({7'b0, n_avec});
        push("ipl_frozen", 8'h02); chk({5'b0, n_ipl});
        as = 1'b0; iack_cycle = 1'b0;
        #1 push("avec_asfall", 8'h00); chk({7'b0, n_avec});
        tick();
        push("avec_rel", 8'h01);  chk({7'b0, n_avec});
        tick();
        push("ipl_unfrozen", 8'h07); chk({5'b0, n_ipl});

        n_irq = 7'h7B;
        tick(3);
        push("l3_ipl", 8'h04);    chk({5'b0, n_ipl});
        iack_cycle = 1'b1; iack_level = 3'd3; as = 1'b1;
        reg_cs = 1'b1; reg_sel = 1'b0; write = 1'b1; data_in = 8'h00;
        tick();
        write = 1'b0;
        push("vec_iack", 8'h7B);  chk({1'b0, n_iack});
        push("vec_avec", 8'h01);  chk({7'b0, n_avec});
        push("mask_new", 8'h00);  chk(data_out);
        tick(63);
        push("vec_iack63", 8'h7B); chk({1'b0, n_iack});
        push("vec_berr63", 8'h00); chk({7'b0, iack_berr});
        tick();
        push("tmo_iack", 8'h7F);  chk({1'b0, n_iack});
        push("tmo_berr", 8'h01);  chk({7'b0, iack_berr});
        tick(3);
        push("tmo_hold", 8'h01);  chk({7'b0, iack_berr});
        as = 1'b0; iack_cycle = 1'b0;
        tick();
        push("tmo_rel", 8'h00);   chk({7'b0, iack_berr});
        wr_mask(8'hFE);
        tick(2);

        iack_cycle = 1'b1; iack_level = 3'd4; as = 1'b1;
        tick();
        push("spur4_berr", 8'h01); chk({7'b0, iack_berr});
        push("spur4_avec", 8'h01); chk({7'b0, n_avec});
        push("spur4_iack", 8'h7F); chk({1'b0, n_iack});
        as = 1'b0; iack_cycle = 1'b0;
        tick();
        push("spur4_rel", 8'h00); chk({7'b0, iack_berr});
        iack_cycle = 1'b1; iack_level = 3'd0; as = 1'b1;
        tick();
        push("spur0_berr", 8'h01); chk({7'b0, iack_berr});
        push("spur0_iack", 8'h7F); chk({1'b0, n_iack});
        as = 1'b0; iack_cycle = 1'b0;
        tick();
        push("spur0_rel", 8'h00); chk({7'b0, iack_berr});

        iack_cycle = 1'b1; iack_level = 3'd3; as = 1'b1;
        tick(2);
        push("pre_rst_iack", 8'h7B); chk({1'b0, n_iack});
        n_reset = 1'b0;
        #1 push("mid_rst_iack", 8'h7F); chk({1'b0, n_iack});
        push("mid_rst_ipl", 8'h07);  chk({5'b0, n_ipl});
        push("mid_rst_berr", 8'h00); chk({7'b0, iack_berr});
        push("mid_rst_mask", 8'h00); chk(data_out);
        as = 1'b0; iack_cycle = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
